// File: rtl/bsg_wormhole_router_input_control_xy.sv
// Wormhole router input-port control: XY route decode, one-hot request on header, one-hot release on tail.
// Optional WH_INPUT_CTRL_PKT_CNT_EN adds a 16-bit wrapping count of released packets (pkt_count_o).
module bsg_wormhole_router_input_control_xy #(
  parameter int flit_width_p   = 32,
  parameter int len_width_p    = 4,
  parameter int x_cord_width_p = 4,
  parameter int y_cord_width_p = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [x_cord_width_p-1:0] my_x_i,
  input  logic [y_cord_width_p-1:0] my_y_i,
  input  logic                      fifo_v_i,
  input  logic [flit_width_p-1:0]   fifo_data_i,
  input  logic                      yumi_i,
`ifdef WH_INPUT_CTRL_PKT_CNT_EN
  output logic [15:0]               pkt_count_o,
`endif
  output logic [4:0]                reqs_o,
  output logic [4:0]                release_o
);

  localparam int HDR_W = len_width_p + x_cord_width_p + y_cord_width_p;

  typedef struct packed {
    logic [y_cord_width_p-1:0] dst_y;
    logic [x_cord_width_p-1:0] dst_x;
    logic [len_width_p-1:0]    len;
  } hdr_t;

  hdr_t hdr;
  assign hdr = hdr_t'(fifo_data_i[HDR_W-1:0]);

  generate
    if (flit_width_p > HDR_W) begin : g_pad
      logic unused_payload;
      assign unused_payload = ^fifo_data_i[flit_width_p-1:HDR_W];
    end
  endgenerate

  logic [len_width_p-1:0] cnt_q, cnt_d;
  logic [4:0]             dir_q, dir_d;
  logic [4:0]             route;
  logic                   is_hdr, is_last, fire;

  // Dimension-ordered: resolve X fully before Y; bit order P,W,E,N,S.
  always_comb begin
    route = 5'b00001;
    if      (hdr.dst_x < my_x_i) route = 5'b00010;
    else if (hdr.dst_x > my_x_i) route = 5'b00100;
    else if (hdr.dst_y < my_y_i) route = 5'b01000;
    else if (hdr.dst_y > my_y_i) route = 5'b10000;
  end

  assign is_hdr  = (cnt_q == '0);
  assign is_last = (is_hdr & (hdr.len == '0)) | (cnt_q == len_width_p'(1));
  assign fire    = fifo_v_i & yumi_i;

  assign reqs_o    = (fifo_v_i & is_hdr & ~reset_i) ? route : 5'b0;
  assign release_o = (fire & is_last & ~reset_i) ? (is_hdr ? route : dir_q) : 5'b0;

  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (fire) begin
      if (is_hdr) begin
        cnt_d = hdr.len;
        dir_d = route;
      end else begin
        cnt_d = cnt_q - len_width_p'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      dir_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end

`ifdef WH_INPUT_CTRL_PKT_CNT_EN
  logic [15:0] pkt_cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i)         pkt_cnt_q <= '0;
    else if (|release_o) pkt_cnt_q <= pkt_cnt_q + 16'd1;
  end

  assign pkt_count_o = pkt_cnt_q;
`endif

endmodule
